// File: rtl/reaction_round_controller.sv
// Round sequencer for the reaction-time game: pseudo-random pre-go delay,
// millisecond reaction scoring, false-start detection and score/run-count
// write-back to the register file.
module reaction_round_controller #(
    parameter int          MIN_DELAY = 1000,
    parameter int          FOUL_MS   = 500,
    parameter int          MAX_RUNS  = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Tick,
    input  logic        StartPulse,
    input  logic        HitPulse,
    output logic        GreenLed,
    output logic        RedLed,
    output logic        WriteEnable,
    output logic [2:0]  WriteAddress,
    output logic [12:0] WriteData,
    output logic [3:0]  RunCount,
    output logic [12:0] BestScore,
    output logic [11:0] DelayTarget,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        GO       = 3'd2,
        WR_SCORE = 3'd3,
        WR_COUNT = 3'd4,
        FOUL     = 3'd5,
        FULL     = 3'd6
    } roundState_t;

    localparam int                FOUL_W       = $clog2(FOUL_MS + 1);
    localparam logic [FOUL_W-1:0] FOUL_LAST    = FOUL_W'(FOUL_MS - 1);
    localparam logic [12:0]       SCORE_MAX    = 13'h1FFF;
    localparam logic [11:0]       MIN_DELAY_12 = 12'(MIN_DELAY);
    localparam logic [3:0]        RUNS_FULL    = 4'(MAX_RUNS);

    roundState_t       state, stateNext;
    logic [15:0]       lfsr, lfsrNext;
    logic [11:0]       delayCnt, delayCntNext;
    logic [12:0]       scoreCnt, scoreCntNext;
    logic [FOUL_W-1:0] foulCnt, foulCntNext;
    logic [3:0]        runCountNext;
    logic [12:0]       bestScoreNext;
    logic [11:0]       delayTargetNext;
    logic              writeEnableNext;
    logic [2:0]        writeAddressNext;
    logic [12:0]       writeDataNext;
    logic              capture;
    logic [12:0]       capturedScore;

    // The state register doubles as the debug state output.
    assign State = state;

    // Next-state, counter and registered-output decode for the round sequence.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        stateNext        = state;
        lfsrNext         = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        delayCntNext     = delayCnt;
        scoreCntNext     = scoreCnt;
        foulCntNext      = foulCnt;
        runCountNext     = RunCount;
        bestScoreNext    = BestScore;
        delayTargetNext  = DelayTarget;
        writeEnableNext  = 1'b0;
        writeAddressNext = '0;
        writeDataNext    = '0;
        capture          = 1'b0;
        capturedScore    = scoreCnt;

        case (state)
            IDLE: begin
                // Start wins over a simultaneous hit; a lone hit is dropped.
                if (StartPulse) begin
                    delayTargetNext = MIN_DELAY_12 + {1'b0, lfsr[10:0]};
                    delayCntNext    = '0;
                    stateNext       = WAIT;
                end
            end
            WAIT: begin
                // A hit before go is a false start, even on the final tick.
                if (HitPulse) begin
                    foulCntNext = '0;
                    stateNext   = FOUL;
                end else if (Tick) begin
                    delayCntNext = delayCnt + 12'd1;
                    if (delayCnt + 12'd1 == DelayTarget) begin
                        scoreCntNext = '0;
                        stateNext    = GO;
                    end
                end
            end
            GO: begin
                // The hit captures the score as it stood before this cycle's tick.
                if (HitPulse) begin
                    capture = 1'b1;
                end else if (Tick) begin
                    if (scoreCnt == SCORE_MAX) begin
                        capture       = 1'b1;
                        capturedScore = SCORE_MAX;
                    end else begin
                        scoreCntNext = scoreCnt + 13'd1;
                    end
                end
                if (capture) begin
                    writeEnableNext  = 1'b1;
                    writeAddressNext = 3'(RunCount + 4'd1);
                    writeDataNext    = capturedScore;
                    stateNext        = WR_SCORE;
                end
            end
            WR_SCORE: begin
                // WriteData still holds the score being written this cycle.
                if (WriteData < BestScore) begin
                    bestScoreNext = WriteData;
                end
                runCountNext     = RunCount + 4'd1;
                writeEnableNext  = 1'b1;
                writeAddressNext = 3'd0;
                writeDataNext    = {9'd0, RunCount + 4'd1};
                stateNext        = WR_COUNT;
            end
            WR_COUNT: begin
                stateNext = (RunCount == RUNS_FULL) ? FULL : IDLE;
            end
            FOUL: begin
                if (Tick) begin
                    if (foulCnt == FOUL_LAST) begin
                        stateNext = IDLE;
                    end else begin
                        foulCntNext = foulCnt + FOUL_W'(1);
                    end
                end
            end
            FULL: begin
                stateNext = FULL;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, counters and all outputs update together; reset overrides everything.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            delayCnt     <= '0;
            scoreCnt     <= '0;
            foulCnt      <= '0;
            RunCount     <= '0;
            BestScore    <= SCORE_MAX;
            DelayTarget  <= '0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
            GreenLed     <= 1'b0;
            RedLed       <= 1'b0;
        end else begin
            state        <= stateNext;
            lfsr         <= lfsrNext;
            delayCnt     <= delayCntNext;
            scoreCnt     <= scoreCntNext;
            foulCnt      <= foulCntNext;
            RunCount     <= runCountNext;
            BestScore    <= bestScoreNext;
            DelayTarget  <= delayTargetNext;
            WriteEnable  <= writeEnableNext;
            WriteAddress <= writeAddressNext;
            WriteData    <= writeDataNext;
            GreenLed     <= (stateNext == GO);
            RedLed       <= (stateNext == FOUL) || (stateNext == FULL);
        end
    end

endmodule

// File: tb/tb_reaction_round_controller.sv
// Scoreboard bench for reaction_round_controller: directed rounds push the
// expected register-file writes; a negedge monitor pops and compares them.
module tb_reaction_round_controller;

    localparam int MIN_DELAY = 1000;
    localparam int FOUL_MS   = 500;
    localparam int MAX_RUNS  = 7;
    localparam int SCORE_MAX = 8191;

    localparam int ST_IDLE     = 0;
    localparam int ST_WAIT     = 1;
    localparam int ST_GO       = 2;
    localparam int ST_WR_SCORE = 3;
    localparam int ST_WR_COUNT = 4;
    localparam int ST_FOUL     = 5;
    localparam int ST_FULL     = 6;

    logic        Clock      = 1'b0;
    logic        Reset      = 1'b1;
    logic        Tick       = 1'b0;
    logic        StartPulse = 1'b0;
    logic        HitPulse   = 1'b0;
    logic        GreenLed;
    logic        RedLed;
    logic        WriteEnable;
    logic [2:0]  WriteAddress;
    logic [12:0] WriteData;
    logic [3:0]  RunCount;
    logic [12:0] BestScore;
    logic [11:0] DelayTarget;
    logic [2:0]  State;

    typedef struct {
        logic [2:0]  addr;
        logic [12:0] data;
    } writeTxn_t;

    writeTxn_t   sbQ[$];
    int          nChecks   = 0;
    int          nFails    = 0;
    int          runModel  = 0;
    int          bestModel = SCORE_MAX;
    logic [15:0] lfsrModel;
    int          fillScores[7] = '{300, 200, 400, 350, 500, 250, 450};

    reaction_round_controller #(
        .MIN_DELAY(MIN_DELAY),
        .FOUL_MS  (FOUL_MS),
        .MAX_RUNS (MAX_RUNS),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Tick        (Tick),
        .StartPulse  (StartPulse),
        .HitPulse    (HitPulse),
        .GreenLed    (GreenLed),
        .RedLed      (RedLed),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .RunCount    (RunCount),
        .BestScore   (BestScore),
        .DelayTarget (DelayTarget),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting every clock.
    always @(posedge Clock) begin
        if (Reset) lfsrModel <= 16'hACE1;
        else       lfsrModel <= {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge Clock) begin
        if (WriteEnable === 1'b1) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL UnexpectedWrite: got addr %0d data %0d, expected no write", WriteAddress, WriteData);
            end else begin
                writeTxn_t exp;
                exp = sbQ.pop_front();
                check("WriteAddress", 32'(WriteAddress), 32'(exp.addr));
                check("WriteData", 32'(WriteData), 32'(exp.data));
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input logic t, input logic s, input logic h);
        Tick = t; StartPulse = s; HitPulse = h;
        @(posedge Clock);
        #1;
        Tick = 1'b0; StartPulse = 1'b0; HitPulse = 1'b0;
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic startRound(output int delay, input logic withHit);
        delay = MIN_DELAY + int'(lfsrModel[10:0]);
        step(1'b0, 1'b1, withHit);
        check("StateWait", 32'(State), ST_WAIT);
        check("DelayTarget", 32'(DelayTarget), delay);
        check("DelayTargetRange", 32'(DelayTarget >= 12'd1000 && DelayTarget <= 12'd3047), 1);
    endtask

    task automatic waitToGo(input int delay);
        waitTicks(delay - 1);
        check("GreenBeforeFinalTick", 32'(GreenLed), 0);
        step(1'b1, 1'b0, 1'b0);
        check("GreenOnFinalTick", 32'(GreenLed), 1);
        check("StateGo", 32'(State), ST_GO);
    endtask

    // Ends a GO phase with the given stimulus and walks the two write cycles.
    task automatic issueScore(input logic t, input logic h, input int score);
        writeTxn_t txn;
        txn.addr = 3'(runModel + 1); txn.data = 13'(score);
        sbQ.push_back(txn);
        txn.addr = 3'd0; txn.data = 13'(runModel + 1);
        sbQ.push_back(txn);
        step(t, 1'b0, h);
        check("WeInWrScore", 32'(WriteEnable), 1);
        check("StateWrScore", 32'(State), ST_WR_SCORE);
        check("GreenDropsInWrScore", 32'(GreenLed), 0);
        step(1'b0, 1'b0, 1'b0);
        runModel++;
        if (score < bestModel) bestModel = score;
        check("StateWrCount", 32'(State), ST_WR_COUNT);
        check("RunCount", 32'(RunCount), runModel);
        step(1'b0, 1'b0, 1'b0);
        check("StateAfterRound", 32'(State), (runModel == MAX_RUNS) ? ST_FULL : ST_IDLE);
        check("WeDropsAfterRound", 32'(WriteEnable), 0);
        check("BestScore", 32'(BestScore), bestModel);
    endtask

    task automatic foulRecovery();
        check("StateFoul", 32'(State), ST_FOUL);
        check("RedInFoul", 32'(RedLed), 1);
        check("GreenInFoul", 32'(GreenLed), 0);
        step(1'b0, 1'b1, 1'b1);
        check("FoulIgnoresPulses", 32'(State), ST_FOUL);
        waitTicks(FOUL_MS - 1);
        check("RedBeforeFoulEnd", 32'(RedLed), 1);
        step(1'b1, 1'b0, 1'b0);
        check("StateAfterFoul", 32'(State), ST_IDLE);
        check("RedAfterFoul", 32'(RedLed), 0);
        check("RunCountAfterFoul", 32'(RunCount), runModel);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL Watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int delay;

        // Reset state
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        Reset = 1'b0;
        check("ResetState", 32'(State), ST_IDLE);
        check("ResetGreen", 32'(GreenLed), 0);
        check("ResetRed", 32'(RedLed), 0);
        check("ResetWe", 32'(WriteEnable), 0);
        check("ResetAddr", 32'(WriteAddress), 0);
        check("ResetData", 32'(WriteData), 0);
        check("ResetRunCount", 32'(RunCount), 0);
        check("ResetBest", 32'(BestScore), SCORE_MAX);
        check("ResetDelayTarget", 32'(DelayTarget), 0);

        // Idle for five clocks; a hit is dropped
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("HitIgnoredInIdle", 32'(State), ST_IDLE);

        // Start, go exactly on DelayTarget ticks, then a 250 ms round
        startRound(delay, 1'b0);
        waitToGo(delay);
        waitTicks(250);
        issueScore(1'b0, 1'b1, 250);

        // False start after 100 ticks, then a start is accepted again
        startRound(delay, 1'b0);
        waitTicks(100);
        step(1'b0, 1'b0, 1'b1);
        check("NoGreenOnFoul", 32'(GreenLed), 0);
        foulRecovery();

        // Start and hit together take the start; hit on final wait tick fouls
        startRound(delay, 1'b1);
        waitTicks(delay - 1);
        step(1'b1, 1'b0, 1'b1);
        foulRecovery();

        // Hit together with a GO tick at score 40 records 40
        startRound(delay, 1'b0);
        waitToGo(delay);
        waitTicks(40);
        issueScore(1'b1, 1'b1, 40);

        // Timeout: score saturates at 8191 and the next tick records it
        startRound(delay, 1'b0);
        waitToGo(delay);
        waitTicks(SCORE_MAX);
        check("StillGoAtSaturation", 32'(State), ST_GO);
        issueScore(1'b1, 1'b0, SCORE_MAX);

        // Reset mid-wait overrides simultaneous start/hit/tick
        startRound(delay, 1'b0);
        waitTicks(10);
        Reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        Reset = 1'b0;
        runModel = 0;
        bestModel = SCORE_MAX;
        check("MidResetState", 32'(State), ST_IDLE);
        check("MidResetGreen", 32'(GreenLed), 0);
        check("MidResetRed", 32'(RedLed), 0);
        check("MidResetRunCount", 32'(RunCount), 0);
        check("MidResetBest", 32'(BestScore), SCORE_MAX);
        check("MidResetDelayTarget", 32'(DelayTarget), 0);

        // Fill all score slots
        for (int r = 0; r < MAX_RUNS; r++) begin
            startRound(delay, 1'b0);
            waitToGo(delay);
            waitTicks(fillScores[r]);
            issueScore(1'b0, 1'b1, fillScores[r]);
        end
        check("FullState", 32'(State), ST_FULL);
        check("FullRed", 32'(RedLed), 1);
        check("FullBest", 32'(BestScore), 200);
        step(1'b0, 1'b1, 1'b0);
        check("EighthStartIgnored", 32'(State), ST_FULL);
        step(1'b1, 1'b0, 1'b1);
        check("HitIgnoredInFull", 32'(State), ST_FULL);
        check("FullRunCount", 32'(RunCount), MAX_RUNS);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("ScoreboardDrained", 32'(sbQ.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
